multicycle_controller: RTL and testbench

Moore-style control FSM for the multicycle RV32I datapath: shared instruction/data memory, a single ALU, and non-architectural registers IR, OldPC, A, WriteData, ALUOut and Data. It sequences lw, sw, R-type, I-type ALU, beq and jal through per-state control words. It sits beside the existing ALU decoder, which consumes ALUOp. It supports optional memory wait states so slower memories can be attached.

---
 rtl/riscv_ctrl_pkg.sv | 57 +++++
 rtl/mem_wait_counter.sv | 27 ++
 rtl/multicycle_controller.sv | 150 +++++++++++++++
 tb/tb_multicycle_controller.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - opcodes, state enum and control encodings for the multicycle RV32I controller
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_ERR      = 4'd11
  } state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_WDATA = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_LW, OP_I: imm_src_of = 2'b00;
      OP_SW:       imm_src_of = 2'b01;
      OP_BEQ:      imm_src_of = 2'b10;
      OP_JAL:      imm_src_of = 2'b11;
      default:     imm_src_of = 2'b00;
    endcase
  endfunction

  // States that touch memory and therefore stretch by the wait-state count.
  function automatic logic is_mem_state(input state_e s);
    is_mem_state = (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// rtl/mem_wait_counter.sv - per-state wait counter, done when count reaches MEM_LAT
module mem_wait_counter #(
  parameter int unsigned MEM_LAT = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic done_o
);

  logic [2:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)   cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 3'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == 3'(MEM_LAT));

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore control FSM for the multicycle RV32I datapath
// Optional trap on unknown opcodes: define ILLEGAL_OP_TRAP_EN.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [1:0] ALUOp,
  output logic [3:0] state_o,
  output logic       illegal_op
);

  state_e state_q, state_d;
  logic   wait_done;
  logic   pc_update, branch, mem_write_s, ir_write_s, reg_write_s;

  mem_wait_counter #(.MEM_LAT(MEM_LAT)) u_wait (
    .clk     (clk),
    .reset   (reset),
    .clear_i (state_d != state_q),
    .en_i    (is_mem_state(state_q) && !wait_done),
    .done_o  (wait_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    pc_update   = 1'b0;
    branch      = 1'b0;
    AdrSrc      = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    ResultSrc   = RES_ALUOUT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_WDATA;
    ALUOp       = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALURESULT;
        ir_write_s = wait_done;
        pc_update  = wait_done;
        if (wait_done) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
`ifdef ILLEGAL_OP_TRAP_EN
          default:      state_d = S_ERR;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (wait_done) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc   = RES_DATA;
        reg_write_s = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        mem_write_s = wait_done;
        if (wait_done) state_d = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_A;
        ALUOp   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        ALUSrcA = SRCA_A;
        ALUOp   = ALUOP_SUB;
        branch  = 1'b1;
        state_d = S_FETCH;
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_FETCH;
    endcase
  end

  // Reset parks the FSM in Fetch asynchronously; strobes must not fire while it is held.
  assign PCWrite  = ~reset & (pc_update | (branch & zero));
  assign MemWrite = ~reset & mem_write_s;
  assign IRWrite  = ~reset & ir_write_s;
  assign RegWrite = ~reset & reg_write_s;
  assign ImmSrc   = imm_src_of(op);
  assign state_o  = state_q;

`ifdef ILLEGAL_OP_TRAP_EN
  logic illegal_q, illegal_d;
  assign illegal_d = illegal_q | (state_d == S_ERR);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= illegal_d;
  end
  assign illegal_op = illegal_q;
`else
  assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller (MEM_LAT 0 and 2)
module tb_multicycle_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rst2, zero;
  logic [6:0] op0, op2;
  logic       pcw0, adr0, mw0, ir0, rw0, ill0;
  logic [1:0] rs0, sa0, sb0, imm0, aluop0;
  logic [3:0] st0;
  logic       pcw2, adr2, mw2, ir2, rw2, ill2;
  logic [1:0] rs2, sa2, sb2, imm2, aluop2;
  logic [3:0] st2;

  multicycle_controller #(.MEM_LAT(0)) dut0 (
    .clk(clk), .reset(rst0), .op(op0), .zero(zero),
    .PCWrite(pcw0), .AdrSrc(adr0), .MemWrite(mw0), .IRWrite(ir0),
    .ResultSrc(rs0), .ALUSrcA(sa0), .ALUSrcB(sb0), .ImmSrc(imm0),
    .RegWrite(rw0), .ALUOp(aluop0), .state_o(st0), .illegal_op(ill0)
  );

  multicycle_controller #(.MEM_LAT(2)) dut2 (
    .clk(clk), .reset(rst2), .op(op2), .zero(zero),
    .PCWrite(pcw2), .AdrSrc(adr2), .MemWrite(mw2), .IRWrite(ir2),
    .ResultSrc(rs2), .ALUSrcA(sa2), .ALUSrcB(sb2), .ImmSrc(imm2),
    .RegWrite(rw2), .ALUOp(aluop2), .state_o(st2), .illegal_op(ill2)
  );

  int checks = 0;
  int failures = 0;

  // {pcupd, branch, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, RegWrite, ALUOp}
  logic [13:0] ctrl_tab [12];
  logic [18:0] sb_q [$];

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic        z;
    logic [23:0] sts;
    int          n;
  } vec_t;
  vec_t vecs [7];

  function automatic logic [23:0] seq(input logic [3:0] a, b, c, d, e, f);
    return {f, e, d, c, b, a};
  endfunction

  function automatic logic [1:0] exp_imm(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0010011: return 2'b00;
      7'b0100011:             return 2'b01;
      7'b1100011:             return 2'b10;
      7'b1101111:             return 2'b11;
      default:                return 2'b00;
    endcase
  endfunction

  function automatic logic [18:0] exp_word(input logic [3:0] s, input logic [6:0] op,
                                           input logic z, input logic last);
    logic [13:0] c;
    logic pcw, mw, ir;
    c   = ctrl_tab[s];
    pcw = (c[13] & last) | (c[12] & z);
    mw  = c[10] & last;
    ir  = c[9] & last;
    return {s, pcw, c[11], mw, ir, c[8:7], c[6:5], c[4:3], exp_imm(op), c[2], c[1:0]};
  endfunction

  function automatic logic [18:0] dut_word(input int lat);
    if (lat == 0) return {st0, pcw0, adr0, mw0, ir0, rs0, sa0, sb0, imm0, rw0, aluop0};
    return {st2, pcw2, adr2, mw2, ir2, rs2, sa2, sb2, imm2, rw2, aluop2};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT in Fetch; returns at the negedge after the last state.
  task automatic run_instr(input string name, input int lat, input logic [6:0] op,
                           input logic z, input logic [23:0] sts, input int n);
    logic [3:0]  s;
    logic [18:0] e;
    int          reps;
    if (lat == 0) op0 = op; else op2 = op;
    zero = z;
    for (int i = 0; i < n; i++) begin
      s    = sts[i*4 +: 4];
      reps = (s == 4'd0 || s == 4'd3 || s == 4'd5) ? lat + 1 : 1;
      for (int r = 0; r < reps; r++) sb_q.push_back(exp_word(s, op, z, r == reps - 1));
    end
    while (sb_q.size() > 0) begin
      #1;
      e = sb_q.pop_front();
      check(name, {13'd0, dut_word(lat)}, {13'd0, e});
      @(negedge clk);
    end
  endtask

  initial begin
    ctrl_tab[0]  = 14'b1_0_0_0_1_10_00_10_0_00;
    ctrl_tab[1]  = 14'b0_0_0_0_0_00_01_01_0_00;
    ctrl_tab[2]  = 14'b0_0_0_0_0_00_10_01_0_00;
    ctrl_tab[3]  = 14'b0_0_1_0_0_00_00_00_0_00;
    ctrl_tab[4]  = 14'b0_0_0_0_0_01_00_00_1_00;
    ctrl_tab[5]  = 14'b0_0_1_1_0_00_00_00_0_00;
    ctrl_tab[6]  = 14'b0_0_0_0_0_00_10_00_0_10;
    ctrl_tab[7]  = 14'b0_0_0_0_0_00_00_00_1_00;
    ctrl_tab[8]  = 14'b0_0_0_0_0_00_10_01_0_10;
    ctrl_tab[9]  = 14'b1_0_0_0_0_00_01_10_0_00;
    ctrl_tab[10] = 14'b0_1_0_0_0_00_10_00_0_01;
    ctrl_tab[11] = 14'b0;

    vecs[0] = '{"lw",    7'b0000011, 1'b0, seq(0, 1, 2, 3, 4, 0), 5};
    vecs[1] = '{"sw",    7'b0100011, 1'b0, seq(0, 1, 2, 5, 0, 0), 4};
    vecs[2] = '{"rtype", 7'b0110011, 1'b1, seq(0, 1, 6, 7, 0, 0), 4};
    vecs[3] = '{"itype", 7'b0010011, 1'b0, seq(0, 1, 8, 7, 0, 0), 4};
    vecs[4] = '{"jal",   7'b1101111, 1'b0, seq(0, 1, 9, 7, 0, 0), 4};
    vecs[5] = '{"beq_t", 7'b1100011, 1'b1, seq(0, 1, 10, 0, 0, 0), 3};
    vecs[6] = '{"beq_nt",7'b1100011, 1'b0, seq(0, 1, 10, 0, 0, 0), 3};

    rst0 = 1'b1; rst2 = 1'b1; op0 = 7'b0000011; op2 = 7'b0110011; zero = 1'b0;
    @(negedge clk); #1;
    check("reset_state_strobes", {st0, pcw0, ir0, mw0, rw0}, {4'd0, 4'b0000});
    check("reset_fetch_srcb", {30'd0, sb0}, {30'd0, 2'b10});
    check("reset_illegal", {31'd0, ill0}, 32'd0);
    @(negedge clk);
    rst0 = 1'b0;

    for (int v = 0; v < 7; v++)
      run_instr(vecs[v].name, 0, vecs[v].op, vecs[v].z, vecs[v].sts, vecs[v].n);

    run_instr("sw_abort", 0, 7'b0100011, 1'b0, seq(0, 1, 2, 0, 0, 0), 3);
    #1;
    check("abort_pre_memwrite", {st0, mw0}, {4'd5, 1'b1});
    rst0 = 1'b1;
    #1;
    check("abort_reset", {st0, mw0, pcw0, ir0, rw0}, {4'd0, 4'b0000});
    @(negedge clk);
    rst0 = 1'b0;

    rst2 = 1'b0;
    run_instr("lat2_rtype", 2, 7'b0110011, 1'b0, seq(0, 1, 6, 7, 0, 0), 4);
    run_instr("lat2_lw",    2, 7'b0000011, 1'b0, seq(0, 1, 2, 3, 4, 0), 5);
    run_instr("lat2_sw",    2, 7'b0100011, 1'b0, seq(0, 1, 2, 5, 0, 0), 4);
    #1;
    check("lat2_back_to_fetch", {28'd0, st2}, 32'd0);
    @(negedge clk);

    run_instr("illegal_decode", 0, 7'b0000000, 1'b0, seq(0, 1, 0, 0, 0, 0), 2);
`ifdef ILLEGAL_OP_TRAP_EN
    for (int k = 0; k < 10; k++) begin
      #1;
      check("err_hold", {st0, ill0, pcw0, ir0, mw0, rw0}, {4'd11, 1'b1, 4'b0000});
      @(negedge clk);
    end
    rst0 = 1'b1;
    #1;
    check("err_reset", {st0, ill0}, {4'd0, 1'b0});
    @(negedge clk);
    rst0 = 1'b0;
`else
    #1;
    check("nop_fetch", {st0, ill0}, {4'd0, 1'b0});
    @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
